// File: rtl/snake_pkg.sv
// Shared snake game definitions: one-hot direction codes, reversal helper and
// the direction controller's state encoding. The game core uses the same codes.
package snake_pkg;

   localparam logic [3:0] NONE  = 4'b0000;
   localparam logic [3:0] RIGHT = 4'b0001;
   localparam logic [3:0] LEFT  = 4'b0010;
   localparam logic [3:0] UP    = 4'b0100;
   localparam logic [3:0] DOWN  = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_t;

   function automatic logic [3:0] opposite(input logic [3:0] dir);
      case (dir)
         RIGHT:   return LEFT;
         LEFT:    return RIGHT;
         UP:      return DOWN;
         DOWN:    return UP;
         default: return NONE;
      endcase
   endfunction

endpackage

// File: rtl/snake_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level and
// a single-cycle pulse on each debounced rising edge.
module snake_debounce #(
   parameter logic [15:0] c_DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(int'(c_DEBOUNCE_CYCLES) + 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         level   <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         press   <= 1'b0;
         // Any sample agreeing with the current level restarts the stability count
         if (sync_p1 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(c_DEBOUNCE_CYCLES)) begin
            level <= sync_p1;
            press <= sync_p1;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/snake_direction_ctrl.sv
// Button front end of the snake game: debounced presses become one paced
// one-hot move pulse per tick, with reversal rejection and freeze on kill.
module snake_direction_ctrl
   import snake_pkg::*;
#(
   parameter logic [15:0] c_DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] c_TICK_CYCLES     = 24'd5000000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [3:0] i_Btn,
   input  logic       i_Kill,
   output logic [3:0] o_Direction,
   output logic [3:0] o_Heading,
   output logic       o_Running
);

   localparam int TW = $clog2(int'(c_TICK_CYCLES));

   logic [3:0]    ev;
   logic [3:0]    press;
   state_t        state, state_nxt;
   logic [3:0]    heading, heading_nxt;
   logic [3:0]    pend, pend_nxt;
   logic [TW-1:0] cnt, cnt_nxt;
   logic          tick_p, tick_nxt;
   logic [3:0]    dir_nxt;
   logic [3:0]    h_ref;
   logic          wrap;

   for (genvar b = 0; b < 4; b++) begin : g_btn
      snake_debounce #(
         .c_DEBOUNCE_CYCLES(c_DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (i_Clk),
         .rst  (i_Rst),
         .btn  (i_Btn[b]),
         .press(ev[b])
      );
   end

   always_comb begin
      press = NONE;
      if (ev[0])      press = RIGHT;
      else if (ev[1]) press = LEFT;
      else if (ev[2]) press = UP;
      else if (ev[3]) press = DOWN;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= IDLE;
         heading     <= NONE;
         pend        <= NONE;
         cnt         <= '0;
         tick_p      <= 1'b0;
         o_Direction <= NONE;
      end else begin
         state       <= state_nxt;
         heading     <= heading_nxt;
         pend        <= pend_nxt;
         cnt         <= cnt_nxt;
         tick_p      <= tick_nxt;
         o_Direction <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      heading_nxt = heading;
      pend_nxt    = pend;
      cnt_nxt     = cnt;
      tick_nxt    = 1'b0;
      dir_nxt     = NONE;
      h_ref       = heading;
      wrap        = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (i_Kill) begin
               state_nxt = DEAD;
            end else if (press != NONE) begin
               state_nxt   = RUN;
               heading_nxt = press;
               pend_nxt    = NONE;
            end
         end
         RUN: begin
            if (i_Kill) begin
               state_nxt = DEAD;
            end else begin
               dir_nxt = tick_p ? heading : NONE;
               wrap    = (cnt == TW'(c_TICK_CYCLES - 24'd1));
               cnt_nxt = wrap ? '0 : cnt + TW'(1);
               if (wrap) begin
                  tick_nxt = 1'b1;
                  if (pend != NONE) heading_nxt = pend;
                  pend_nxt = NONE;
               end
               // A press in the wrap cycle is judged against the freshly committed heading
               h_ref = heading_nxt;
               if (press != NONE && press != h_ref && press != opposite(h_ref)) begin
                  pend_nxt = press;
               end
            end
         end
         DEAD: begin
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign o_Heading = heading;
   assign o_Running = (state == RUN);

endmodule

// File: tb/tb_snake_direction_ctrl.sv
// Directed bench for snake_direction_ctrl with short debounce (4) and tick (8)
// periods; edge numbers below count posedges from the first stimulus edge.
module tb_snake_direction_ctrl;
   import snake_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kill = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic [3:0] dir;
   logic [3:0] head;
   logic       running;

   int t = 0;
   int base = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   snake_direction_ctrl #(
      .c_DEBOUNCE_CYCLES(16'd4),
      .c_TICK_CYCLES    (24'd8)
   ) dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Btn      (btn),
      .i_Kill     (kill),
      .o_Direction(dir),
      .o_Heading  (head),
      .o_Running  (running)
   );

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic goto_edge(input int e);
      while (t < e) step();
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, t, obs, exp);
      end
   endtask

   task automatic check_run(input string tag, input logic exp);
      check(tag, {3'b000, running}, {3'b000, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish (edge %0d)", t);
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      step();
      step();
      check("rst_dir", dir, NONE);
      check("rst_head", head, NONE);
      check_run("rst_run", 1'b0);

      // First press from IDLE: event at edge 6, RUN at 7, pulses at 16/24/32
      rst = 1'b0;
      btn = RIGHT;
      t = -1;
      goto_edge(5);  check_run("idle_e5", 1'b0);
      goto_edge(6);  check_run("idle_e6", 1'b0);
      goto_edge(7);  check_run("run_e7", 1'b1);
      check("head_e7", head, RIGHT);
      check("dir_e7", dir, NONE);
      btn = NONE;
      goto_edge(15); check("dir_e15", dir, NONE);
      goto_edge(16); check("dir_e16", dir, RIGHT);
      goto_edge(17); check("dir_e17", dir, NONE);
      goto_edge(24); check("dir_e24", dir, RIGHT);
      goto_edge(25); check("dir_e25", dir, NONE);
      goto_edge(32); check("dir_e32", dir, RIGHT);

      // Reversal LEFT rejected, then UP accepted
      btn = LEFT;
      goto_edge(40); check("dir_e40", dir, RIGHT);
      btn = NONE;
      goto_edge(48); check("rev_dir_e48", dir, RIGHT);
      check("rev_head_e48", head, RIGHT);
      btn = UP;
      goto_edge(56); check("dir_e56", dir, RIGHT);
      btn = NONE;
      goto_edge(64); check("up_dir_e64", dir, UP);
      check("up_head_e64", head, UP);

      // Heading UP: RIGHT pending, then DOWN rejected against UP (not pending)
      btn = RIGHT;
      goto_edge(66);
      btn = RIGHT | DOWN;
      goto_edge(72); check("dir_e72", dir, UP);
      goto_edge(74);
      btn = NONE;
      goto_edge(80); check("pend_dir_e80", dir, RIGHT);
      check("pend_head_e80", head, RIGHT);

      // Back to UP, then simultaneous RIGHT+LEFT: RIGHT has priority
      btn = UP;
      goto_edge(88); check("dir_e88", dir, RIGHT);
      btn = NONE;
      goto_edge(96); check("dir_e96", dir, UP);
      btn = RIGHT | LEFT;
      goto_edge(104); check("dir_e104", dir, UP);
      btn = NONE;
      goto_edge(112); check("prio_dir_e112", dir, RIGHT);
      check("prio_head_e112", head, RIGHT);

      // Kill one cycle before the wrap: no further pulses, buttons ignored
      goto_edge(117);
      kill = 1'b1;
      goto_edge(118); check_run("kill_run_e118", 1'b0);
      btn = LEFT;
      goto_edge(120); check("kill_dir_e120", dir, NONE);
      check("kill_head_e120", head, RIGHT);
      goto_edge(128); check("kill_dir_e128", dir, NONE);
      check("kill_head_e128", head, RIGHT);
      check_run("kill_run_e128", 1'b0);
      goto_edge(136); check("kill_dir_e136", dir, NONE);

      // Reset out of DEAD, then a new press restarts the game
      rst  = 1'b1;
      kill = 1'b0;
      btn  = NONE;
      goto_edge(137);
      check("rst2_dir", dir, NONE);
      check("rst2_head", head, NONE);
      check_run("rst2_run", 1'b0);
      rst = 1'b0;
      btn = UP;
      goto_edge(144); check_run("restart_e144", 1'b0);
      goto_edge(145); check_run("restart_e145", 1'b1);
      check("restart_head", head, UP);

      // Reset mid-debounce and mid-tick: the held button needs the full latency again
      btn = NONE;
      goto_edge(150);
      btn = RIGHT;
      goto_edge(153);
      rst = 1'b1;
      goto_edge(154);
      check("mid_rst_dir", dir, NONE);
      check("mid_rst_head", head, NONE);
      check_run("mid_rst_run", 1'b0);
      rst = 1'b0;
      goto_edge(161); check_run("mid_e161", 1'b0);
      goto_edge(162); check_run("mid_e162", 1'b1);
      check("mid_head_e162", head, RIGHT);
      btn = NONE;
      goto_edge(170); check("mid_dir_e170", dir, NONE);
      goto_edge(171); check("mid_dir_e171", dir, RIGHT);

      // Bouncing DOWN in IDLE: no event until the level holds steady
      rst = 1'b1;
      goto_edge(172);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         btn = ((i % 4) < 2) ? DOWN : NONE;
         step();
      end
      check_run("bounce_run", 1'b0);
      check("bounce_head", head, NONE);
      btn = DOWN;
      base = t;
      goto_edge(base + 7); check_run("steady_e6", 1'b0);
      goto_edge(base + 8); check_run("steady_e7", 1'b1);
      check("steady_head", head, DOWN);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/snake_direction_ctrl.md
# snake_direction_ctrl

Upstream input stage of the snake game. Synchronizes and debounces four raw push-buttons, then converts presses into a paced one-hot move command for the game core's 4-bit direction input. Paces moves with a programmable tick, rejects 180° reversals, and freezes once the core reports a kill. The core advances one cell per cycle in which its direction input is non-zero. This block emits exactly one non-zero cycle per tick.

## Interface
- c_DEBOUNCE_CYCLES, 16'd50000: consecutive stable synced samples required before a button's debounced level changes.
- c_TICK_CYCLES, 24'd5000000: clock cycles per snake move.
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset i_Rst, synchronous, active-high.
- i_Btn  in  4  raw asynchronous buttons, active-high: [0] right, [1] left, [2] up, [3] down.
- i_Kill  in  1  kill flag from game core; level.
- o_Direction  out  4  one-hot move pulse: 0001 RIGHT, 0010 LEFT, 0100 UP, 1000 DOWN. 0000 when no move.
- o_Heading  out  4  committed heading (same encoding). 0000 before first move.
- o_Running  out  1  high in RUN state.

## Operation
- Per button: 2-flop synchronizer, then debounce counter. The counter clears whenever the synced value equals the debounced value. When it reaches c_DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
- Press event: debounced 0→1, one cycle wide. Releases generate nothing.
- Simultaneous press events resolve with priority RIGHT > LEFT > UP > DOWN. Only one event is used per cycle.
- Reference heading H_ref is the heading after any commit in the current cycle.
- A press is rejected if it is the opposite of H_ref (RIGHT↔LEFT, UP↔DOWN). It is also rejected if it equals H_ref.
- Otherwise the press is accepted into the pending register. Last accepted press wins; an earlier pending value is overwritten.
- FSM states:
  - IDLE: tick counter held at 0 and outputs 0. The first press event of any direction is accepted (no reversal check): heading ← press, pending cleared, counter ← 0, go to RUN.
  - RUN: counter increments and wraps from c_TICK_CYCLES-1 to 0. In the wrap cycle, heading ← pending if pending is valid, and pending is cleared. At the next edge, o_Direction ← the new heading.
  - DEAD: entered from any state when i_Kill=1. o_Direction forced 0000 from the next cycle. Press events are ignored. o_Heading holds its value. The only exit is i_Rst.
- If i_Kill and a tick coincide, the tick is suppressed: no pulse and no commit.

## Timing
- Reset (i_Rst high at an edge) sets the following. It wins over all other inputs, including mid-debounce and mid-tick.
  - o_Direction=0000, o_Heading=0000, o_Running=0.
  - State IDLE, pending empty, tick counter 0.
  - All debounce counters 0, synchronizer and debounced levels 0.
- Debounce latency: a raw level stable from edge 0 gives a debounced rise and press event at edge c_DEBOUNCE_CYCLES+2. Any glitch shorter than c_DEBOUNCE_CYCLES synced samples produces no event.
- IDLE→RUN occurs at the edge after the press event. o_Running rises at that edge.
- First o_Direction pulse appears c_TICK_CYCLES+1 edges after entering RUN. Subsequent pulses are exactly c_TICK_CYCLES cycles apart, each exactly one cycle wide.
- A press accepted at least one cycle before the wrap cycle takes effect on that tick's pulse.
- A press event in the wrap cycle is checked against the newly committed heading and applies to the following tick.
- Counter width is $clog2(c_TICK_CYCLES). The comparison against c_TICK_CYCLES-1 uses the full width. c_TICK_CYCLES ≥ 2 and c_DEBOUNCE_CYCLES ≥ 1 are required; the block is unspecified outside these ranges.

## Structure
- Shared package snake_pkg holds:
  - direction constants RIGHT/LEFT/UP/DOWN (4-bit one-hot) and NONE=4'b0000;
  - an opposite() function;
  - FSM state encoding IDLE/RUN/DEAD.
  - The game core uses the same direction constants.
- Sub-module snake_debounce: synchronizer, counter, debounced level and rise pulse for one button, parameterized by c_DEBOUNCE_CYCLES. Instantiated 4×.
- Top holds the priority encoder, acceptance logic, pending register, tick counter and FSM.

## Test plan
Parameters for all scenarios: c_DEBOUNCE_CYCLES=4, c_TICK_CYCLES=8.
- Reset, then i_Btn=0001 held → press event at edge 6; RUN and o_Heading=0001 at edge 7; o_Direction=0001 at edges 16, 24, 32, each one cycle wide.
- In RUN heading RIGHT, press LEFT (0010) → rejected; pulses remain 0001. Then press UP (0100) → next pulse 0100, and o_Heading=0100.
- Bounce on i_Btn[3] toggling every 2 cycles for 20 cycles, then steady 1 → no event during bouncing; exactly one press event 6 edges after steady.
- Heading UP, press RIGHT then DOWN before the next tick. DOWN is not checked against pending RIGHT; it is rejected as the reverse of UP. Next pulse is 0001. Also press 0011 in one cycle from heading UP → RIGHT wins, pulse 0001.
- i_Kill=1 one cycle before a wrap → no pulse at that tick or after; buttons ignored. i_Rst → all outputs 0 and state IDLE; a new press restarts the game.
- Assert i_Rst for 1 cycle mid-debounce and mid-tick → all counters 0; the held button needs the full 6 edges again after reset release.
